debug_unit: RTL

//  Host-side controller for the MIPS pipeline. Decodes command bytes from a UART receiver.

---
 rtl/debug_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART command bytes, runs/steps the pipeline and streams a
// PC/cycle-count/register/memory snapshot out after every stop. Optional macro: DEBUG_UNIT_BREAKPOINT_EN.
module debug_unit #(
    parameter int NB_REG        = 32,
    parameter int NB_REG_ADDR   = 5,
    parameter int REGFILE_DEPTH = 32,
    parameter int NB_DM_ADDR    = 10,
    parameter int N_DUMP_MEM    = 16,
    parameter int NB_BYTE       = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_BYTE-1:0]     i_rx_data,
    input  logic                   i_rx_valid,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_pipe_valid,
    output logic                   o_pipe_reset,
    input  logic                   i_halt,
    input  logic [NB_REG-1:0]      i_pc,
    output logic [NB_REG_ADDR-1:0] o_rf_addr,
    input  logic [NB_REG-1:0]      i_rf_data,
    output logic [NB_DM_ADDR-1:0]  o_dm_addr,
    input  logic [NB_REG-1:0]      i_dm_data,
    output logic                   o_idle
);

    localparam int N_WORDS        = 2 + REGFILE_DEPTH + N_DUMP_MEM;
    localparam int IDX_W          = $clog2(N_WORDS);
    localparam int BYTES_PER_WORD = NB_REG / NB_BYTE;
    localparam int BC_W           = $clog2(BYTES_PER_WORD);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_WORDS - 1);
    localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
    localparam logic [NB_BYTE-1:0] CMD_CONT  = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP  = NB_BYTE'(8'h44);
    localparam logic [NB_BYTE-1:0] CMD_RESET = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_HALT  = NB_BYTE'(8'h48);
`ifdef DEBUG_UNIT_BREAKPOINT_EN
    localparam logic [NB_BYTE-1:0] CMD_BP    = NB_BYTE'(8'h42);
`endif

    typedef enum logic [2:0] {
        IDLE, RUN, STEP, LOAD, SEND
`ifdef DEBUG_UNIT_BREAKPOINT_EN
        , BPLOAD
`endif
    } state_t;

    state_t                  state;
    logic [NB_REG-1:0]       cycle_count;
    logic [NB_REG-1:0]       pc_snap;
    logic [NB_REG-1:0]       tx_word;
    logic [NB_REG-1:0]       word_value;
    logic [IDX_W-1:0]        word_idx;
    logic [IDX_W-1:0]        next_idx;
    logic [BC_W-1:0]         byte_cnt;
    logic                    load_wait;
    logic                    stop_req;
`ifdef DEBUG_UNIT_BREAKPOINT_EN
    logic [NB_REG-1:0]       bp_pc;
    logic [BC_W-1:0]         bp_cnt;
`endif

    // Dump words 2.. map onto the register file, the rest onto data memory; out-of-range reads park at 0.
    function automatic logic [NB_REG_ADDR-1:0] rf_addr_of(input logic [IDX_W-1:0] idx);
        int off;
        off = int'(idx) - 2;
        return (off >= 0 && off < REGFILE_DEPTH) ? NB_REG_ADDR'(off) : '0;
    endfunction

    function automatic logic [NB_DM_ADDR-1:0] dm_addr_of(input logic [IDX_W-1:0] idx);
        int off;
        off = int'(idx) - 2 - REGFILE_DEPTH;
        return (off >= 0 && off < N_DUMP_MEM) ? NB_DM_ADDR'(off) : '0;
    endfunction

    assign next_idx = word_idx + IDX_W'(1);

`ifdef DEBUG_UNIT_BREAKPOINT_EN
    assign o_idle = (state == IDLE) || (state == BPLOAD);
`else
    assign o_idle = (state == IDLE);
`endif

    always_comb begin
        stop_req = i_halt || (i_rx_valid && i_rx_data == CMD_HALT);
`ifdef DEBUG_UNIT_BREAKPOINT_EN
        if (i_pc == bp_pc) stop_req = 1'b1;
`endif
    end

    always_comb begin
        if (word_idx == '0)                          word_value = pc_snap;
        else if (word_idx == IDX_W'(1))              word_value = cycle_count;
        else if (int'(word_idx) < 2 + REGFILE_DEPTH) word_value = i_rf_data;
        else                                         word_value = i_dm_data;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            cycle_count  <= '0;
            pc_snap      <= '0;
            tx_word      <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            load_wait    <= 1'b0;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
            o_pipe_valid <= 1'b0;
            o_pipe_reset <= 1'b0;
            o_rf_addr    <= '0;
            o_dm_addr    <= '0;
`ifdef DEBUG_UNIT_BREAKPOINT_EN
            bp_pc        <= '1;
            bp_cnt       <= '0;
`endif
        end else begin
            o_pipe_reset <= 1'b0;
            if (o_pipe_valid) cycle_count <= cycle_count + NB_REG'(1);
            case (state)
                IDLE: if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_CONT: begin
                            state        <= RUN;
                            o_pipe_valid <= 1'b1;
                        end
                        CMD_STEP: begin
                            state        <= STEP;
                            o_pipe_valid <= 1'b1;
                        end
                        CMD_DUMP: begin
                            state     <= LOAD;
                            pc_snap   <= i_pc;
                            word_idx  <= '0;
                            load_wait <= 1'b0;
                            o_rf_addr <= rf_addr_of('0);
                            o_dm_addr <= dm_addr_of('0);
                        end
                        CMD_RESET: begin
                            o_pipe_reset <= 1'b1;
                            cycle_count  <= '0;
                        end
`ifdef DEBUG_UNIT_BREAKPOINT_EN
                        CMD_BP: begin
                            state  <= BPLOAD;
                            bp_cnt <= '0;
                        end
`endif
                        default: ;
                    endcase
                end
                // The stop cycle still advances the pipeline; the PC is frozen from that same cycle.
                RUN: if (stop_req) begin
                    state        <= LOAD;
                    o_pipe_valid <= 1'b0;
                    pc_snap      <= i_pc;
                    word_idx     <= '0;
                    load_wait    <= 1'b0;
                    o_rf_addr    <= rf_addr_of('0);
                    o_dm_addr    <= dm_addr_of('0);
                end
                STEP: begin
                    state        <= LOAD;
                    o_pipe_valid <= 1'b0;
                    pc_snap      <= i_pc;
                    word_idx     <= '0;
                    load_wait    <= 1'b0;
                    o_rf_addr    <= rf_addr_of('0);
                    o_dm_addr    <= dm_addr_of('0);
                end
                LOAD: begin
                    if (!load_wait) begin
                        load_wait <= 1'b1;
                    end else begin
                        state      <= SEND;
                        tx_word    <= word_value;
                        o_tx_data  <= word_value[NB_BYTE-1:0];
                        o_tx_valid <= 1'b1;
                        byte_cnt   <= '0;
                    end
                end
                SEND: begin
                    if (o_tx_valid) begin
                        if (i_tx_ready) begin
                            o_tx_valid <= 1'b0;
                            if (byte_cnt == LAST_BYTE) begin
                                if (word_idx == LAST_IDX) begin
                                    state <= IDLE;
                                end else begin
                                    state     <= LOAD;
                                    word_idx  <= next_idx;
                                    load_wait <= 1'b0;
                                    o_rf_addr <= rf_addr_of(next_idx);
                                    o_dm_addr <= dm_addr_of(next_idx);
                                end
                            end else begin
                                byte_cnt <= byte_cnt + BC_W'(1);
                                tx_word  <= tx_word >> NB_BYTE;
                            end
                        end
                    end else begin
                        o_tx_data  <= tx_word[NB_BYTE-1:0];
                        o_tx_valid <= 1'b1;
                    end
                end
`ifdef DEBUG_UNIT_BREAKPOINT_EN
                BPLOAD: if (i_rx_valid) begin
                    bp_pc  <= {i_rx_data, bp_pc[NB_REG-1:NB_BYTE]};
                    bp_cnt <= bp_cnt + BC_W'(1);
                    if (bp_cnt == LAST_BYTE) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
